// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared ROM geometry and burst reader state encoding
package rom_pkg;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2
  } state_e;

endpackage

// File: rtl/rom_burst_reader_if.sv
// rtl/rom_burst_reader_if.sv - command, ROM and stream signals of the burst reader
interface rom_burst_reader_if #(
  parameter int ADDR_W = rom_pkg::ROM_ADDR_W,
  parameter int DATA_W = rom_pkg::ROM_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  burst_len;
  logic              busy;
  logic              done;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  // Reader side: consumes commands and ROM data, drives the ROM and the stream
  modport master (
    input  start, start_addr, burst_len, rom_data, m_ready,
    output busy, done, rom_en, rom_addr, m_valid, m_data, m_last
  );

  // Environment side: command source, ROM and stream sink
  modport slave (
    output start, start_addr, burst_len, rom_data, m_ready,
    input  busy, done, rom_en, rom_addr, m_valid, m_data, m_last
  );

endinterface

// File: rtl/rom_burst_reader.sv
// rtl/rom_burst_reader.sv - streams a wrapping burst of words out of a registered single-port ROM
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  rom_burst_reader_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              done_q, done_d;

  logic              rom_en_c;
  logic [ADDR_W-1:0] rom_addr_c;
  logic              m_valid_c;
  logic [DATA_W-1:0] m_data_c;
  logic              m_last_c;

  // State, burst address/count and the done pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  // Next state and outputs; the ROM is only enabled when a new word is wanted,
  // so its held output keeps m_data stable while the sink stalls
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    rom_en_c    = 1'b0;
    rom_addr_c  = '0;
    m_valid_c   = 1'b0;
    m_data_c    = '0;
    m_last_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.burst_len != '0)) begin
          addr_d      = bus.start_addr;
          remaining_d = bus.burst_len;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        rom_en_c   = 1'b1;
        rom_addr_c = addr_q;
        state_d    = OUT;
      end
      OUT: begin
        m_valid_c = 1'b1;
        m_data_c  = bus.rom_data;
        m_last_c  = (remaining_q == LEN_W'(1));
        if (bus.m_ready) begin
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            rom_en_c    = 1'b1;
            rom_addr_c  = addr_q + ADDR_W'(1);
            addr_d      = addr_q + ADDR_W'(1);
            remaining_d = remaining_q - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.rom_en   = rom_en_c;
  assign bus.rom_addr = rom_addr_c;
  assign bus.m_valid  = m_valid_c;
  assign bus.m_data   = m_data_c;
  assign bus.m_last   = m_last_c;

endmodule
